// File: rtl/decoder_gate_scheduler.sv
// decoder_gate_scheduler: round-robin scheduler that time-shares a single
// 2-to-4 decoder among N_REQ requesters. Each transaction evaluates one
// 1-bit gate (NOT/AND/OR/XOR) from the decoder outputs. Only one transaction
// is in flight at a time: IDLE (grant) -> EVAL (decode) -> RESP (handshake).

// Shared 2-to-4 one-hot decoder.
module decoder_2x4 (
   input  logic [1:0] sel_i,
   output logic [3:0] dec_o
);

   // One-hot decode of the 2-bit select.
   always_comb begin
      dec_o = 4'b0001 << sel_i;
   end

endmodule

module decoder_gate_scheduler #(
   parameter int N_REQ = 4,
   parameter int ID_W  = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N_REQ-1:0]     req_valid,
   input  logic [2*N_REQ-1:0]   req_op,
   input  logic [N_REQ-1:0]     req_a,
   input  logic [N_REQ-1:0]     req_b,
   output logic [N_REQ-1:0]     req_ready,
   output logic                 resp_valid,
   input  logic                 resp_ready,
   output logic [ID_W-1:0]      resp_id,
   output logic                 resp_data,
   output logic                 dec_err
);

   localparam logic [1:0] OP_NOT = 2'b00;
   localparam logic [1:0] OP_AND = 2'b01;
   localparam logic [1:0] OP_OR  = 2'b10;
   localparam logic [1:0] OP_XOR = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EVAL = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [1:0]        op_q, op_d;
   logic              a_q, a_d;
   logic              b_q, b_d;
   logic [ID_W-1:0]   owner_q, owner_d;
   logic              resp_valid_q, resp_valid_d;
   logic              resp_data_q, resp_data_d;
   logic              dec_err_q, dec_err_d;

   // Candidate requester indices in round-robin order starting at rr_ptr.
   logic [ID_W-1:0]   cand_idx [N_REQ];
   logic [N_REQ-1:0]  cand_vld;
   logic [ID_W-1:0]   grant_idx;
   logic              grant_en;

   logic [1:0]        dec_sel;
   logic [3:0]        dec_w;
   logic              dec_onehot;
   logic              gate_res;

   for (genvar gi = 0; gi < N_REQ; gi++) begin : g_cand
      logic [ID_W:0] sum;
      assign sum           = {1'b0, rr_ptr_q} + (ID_W+1)'(gi);
      assign cand_idx[gi]  = (sum >= (ID_W+1)'(N_REQ)) ? ID_W'(sum - (ID_W+1)'(N_REQ))
                                                       : sum[ID_W-1:0];
      assign cand_vld[gi]  = req_valid[cand_idx[gi]];
   end

   // Pick the first valid candidate; scanning high-to-low lets the lowest offset win.
   always_comb begin
      grant_idx = cand_idx[0];
      for (int k = N_REQ - 1; k >= 0; k--) begin
         if (cand_vld[k]) begin
            grant_idx = cand_idx[k];
         end
      end
   end

   // A grant is only issued from IDLE, and never while reset is held.
   assign grant_en = (state_q == IDLE) && !rst && (|req_valid);

   for (genvar gi = 0; gi < N_REQ; gi++) begin : g_ready
      assign req_ready[gi] = grant_en && (grant_idx == ID_W'(gi));
   end

   // NOT only looks at a, so b is forced low to keep the lookup to w[0]/w[2].
   assign dec_sel = (op_q == OP_NOT) ? {a_q, 1'b0} : {a_q, b_q};

   decoder_2x4 u_dec (
      .sel_i (dec_sel),
      .dec_o (dec_w)
   );

   // A healthy decoder output has exactly one bit set.
   assign dec_onehot = (dec_w != 4'b0000) && ((dec_w & (dec_w - 4'b0001)) == 4'b0000);

   // Gate result built purely from decoder lines.
   always_comb begin
      gate_res = 1'b0;
      case (op_q)
         OP_NOT:  gate_res = dec_w[0];
         OP_AND:  gate_res = dec_w[3];
         OP_OR:   gate_res = dec_w[1] | dec_w[2] | dec_w[3];
         OP_XOR:  gate_res = dec_w[1] | dec_w[2];
         default: gate_res = 1'b0;
      endcase
   end

   // Next-state and datapath update for the grant/evaluate/respond sequence.
   always_comb begin
      state_d      = state_q;
      rr_ptr_d     = rr_ptr_q;
      op_d         = op_q;
      a_d          = a_q;
      b_d          = b_q;
      owner_d      = owner_q;
      resp_valid_d = resp_valid_q;
      resp_data_d  = resp_data_q;
      dec_err_d    = dec_err_q;
      case (state_q)
         IDLE: begin
            if (grant_en) begin
               op_d     = req_op[{grant_idx, 1'b0} +: 2];
               a_d      = req_a[grant_idx];
               b_d      = req_b[grant_idx];
               owner_d  = grant_idx;
               rr_ptr_d = (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
               state_d  = EVAL;
            end
         end
         EVAL: begin
            resp_data_d  = gate_res;
            resp_valid_d = 1'b1;
            if (!dec_onehot) begin
               dec_err_d = 1'b1;
            end
            state_d = RESP;
         end
         RESP: begin
            if (resp_ready) begin
               resp_valid_d = 1'b0;
               state_d      = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Datapath registers; reset drops any in-flight transaction.
   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr_q     <= '0;
         op_q         <= 2'b00;
         a_q          <= 1'b0;
         b_q          <= 1'b0;
         owner_q      <= '0;
         resp_valid_q <= 1'b0;
         resp_data_q  <= 1'b0;
         dec_err_q    <= 1'b0;
      end else begin
         rr_ptr_q     <= rr_ptr_d;
         op_q         <= op_d;
         a_q          <= a_d;
         b_q          <= b_d;
         owner_q      <= owner_d;
         resp_valid_q <= resp_valid_d;
         resp_data_q  <= resp_data_d;
         dec_err_q    <= dec_err_d;
      end
   end

   assign resp_valid = resp_valid_q;
   assign resp_id    = owner_q;
   assign resp_data  = resp_data_q;
   assign dec_err    = dec_err_q;

endmodule

// File: tb/tb_decoder_gate_scheduler.sv
// Bench for decoder_gate_scheduler: a transaction-level model predicts grants,
// responses and the error flag each cycle; directed tests pin literal values.
module tb_decoder_gate_scheduler;

   localparam int N = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] req_valid;
   logic [7:0] req_op;
   logic [3:0] req_a;
   logic [3:0] req_b;
   logic [3:0] req_ready;
   logic       resp_valid;
   logic       resp_ready;
   logic [1:0] resp_id;
   logic       resp_data;
   logic       dec_err;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   decoder_gate_scheduler #(.N_REQ(4), .ID_W(2)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_op     (req_op),
      .req_a      (req_a),
      .req_b      (req_b),
      .req_ready  (req_ready),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_id    (resp_id),
      .resp_data  (resp_data),
      .dec_err    (dec_err)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Gate semantics straight from the boolean definitions.
   function automatic bit ref_gate(input logic [1:0] op, input logic a, input logic b);
      case (op)
         2'b00:   return !a;
         2'b01:   return a & b;
         2'b10:   return a | b;
         default: return a ^ b;
      endcase
   endfunction

   // ---------------- transaction-level model ----------------
   bit model_en   = 1'b0;
   bit m_busy     = 1'b0;
   int m_age      = 0;     // clock edges since the grant edge
   int m_rr       = 0;
   bit m_err      = 1'b0;
   int m_id       = 0;
   bit m_data     = 1'b0;
   bit fault_on   = 1'b0;
   bit fault_data = 1'b0;

   always @(negedge clk) begin
      logic [3:0] exp_rdy;
      int         win;
      bit         exp_rv;
      if (model_en) begin
         exp_rdy = 4'b0000;
         win     = -1;
         if (!rst && !m_busy) begin
            for (int k = 0; k < N; k++) begin
               if (win < 0 && req_valid[(m_rr + k) % N]) win = (m_rr + k) % N;
            end
         end
         if (win >= 0) exp_rdy[win] = 1'b1;
         chk("model_req_ready", 32'(req_ready), 32'(exp_rdy));
         exp_rv = m_busy && (m_age >= 2);
         chk("model_resp_valid", 32'(resp_valid), 32'(exp_rv));
         if (exp_rv) begin
            chk("model_resp_id", 32'(resp_id), 32'(m_id));
            chk("model_resp_data", 32'(resp_data), 32'(m_data));
         end
         chk("model_dec_err", 32'(dec_err), 32'(m_err));

         if (rst) begin
            m_busy = 1'b0; m_rr = 0; m_err = 1'b0; m_age = 0;
         end else if (m_busy) begin
            if (m_age == 1 && fault_on) begin
               m_err  = 1'b1;
               m_data = fault_data;
            end
            if (m_age >= 2 && resp_ready) begin
               m_busy = 1'b0;
               $display("txn id=%0d data=%0d done at cycle %0d", m_id, m_data, cyc);
            end else begin
               m_age++;
            end
         end else if (win >= 0) begin
            m_busy = 1'b1;
            m_age  = 1;
            m_id   = win;
            m_data = ref_gate(req_op[2*win +: 2], req_a[win], req_b[win]);
            m_rr   = (win + 1) % N;
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input int id, input logic [1:0] op, input logic a, input logic b,
                        output int gcyc);
      bit ok;
      ok   = 1'b0;
      gcyc = 0;
      req_valid[id]     = 1'b1;
      req_op[2*id +: 2] = op;
      req_a[id]         = a;
      req_b[id]         = b;
      for (int t = 0; t < 20; t++) begin
         @(negedge clk);
         if (req_ready[id]) begin
            ok   = 1'b1;
            gcyc = cyc;
         end
         @(posedge clk);
         #1;
         if (ok) break;
      end
      req_valid[id] = 1'b0;
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL grant_timeout id=%0d: got no req_ready, required a grant within 20 cycles", id);
      end
   endtask

   task automatic wait_resp(output int rcyc);
      bit ok;
      ok   = 1'b0;
      rcyc = 0;
      for (int t = 0; t < 20; t++) begin
         @(negedge clk);
         if (resp_valid) begin
            ok   = 1'b1;
            rcyc = cyc;
            break;
         end
      end
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL resp_timeout: got resp_valid=0, required 1 within 20 cycles");
      end
   endtask

   task automatic do_reset(input int n);
      rst = 1'b1;
      repeat (n) step();
      rst = 1'b0;
   endtask

   // ---------------- directed tests ----------------
   initial begin
      logic [15:0] tt;
      int          g, r;
      int          order [5];
      int          gtime [5];
      int          ng;
      int          exp_order [5];

      rst        = 1'b1;
      req_valid  = 4'b1111;
      req_op     = 8'h00;
      req_a      = 4'b0000;
      req_b      = 4'b0000;
      resp_ready = 1'b0;

      // Reset with every requester valid: nothing may be granted.
      step();
      model_en = 1'b1;
      @(negedge clk);
      chk("rst_req_ready", 32'(req_ready), 32'h0);
      chk("rst_resp_valid", 32'(resp_valid), 32'h0);
      chk("rst_resp_id", 32'(resp_id), 32'h0);
      chk("rst_resp_data", 32'(resp_data), 32'h0);
      chk("rst_dec_err", 32'(dec_err), 32'h0);
      step();
      rst = 1'b0;
      @(negedge clk);
      chk("first_grant_id0", 32'(req_ready), 32'h1);
      step();
      req_valid  = 4'b0000;
      resp_ready = 1'b1;
      repeat (4) step();

      // Truth table on requester 0; bit index = op*4 + {a,b}.
      tt = 16'b0110_1110_1000_0011;
      for (int op = 0; op < 4; op++) begin
         for (int ab = 0; ab < 4; ab++) begin
            issue(0, 2'(op), ab[1], ab[0], g);
            wait_resp(r);
            chk("tt_latency", 32'(r - g), 32'd2);
            chk("tt_data", 32'(resp_data), 32'(tt[op*4 + ab]));
            step();
         end
      end

      // Round robin with all requesters valid.
      do_reset(1);
      req_op    = 8'b11_10_01_00;
      req_a     = 4'b1010;
      req_b     = 4'b0110;
      req_valid = 4'b1111;
      ng = 0;
      for (int t = 0; t < 40 && ng < 5; t++) begin
         @(negedge clk);
         if (|req_ready) begin
            for (int k = 0; k < N; k++) if (req_ready[k]) order[ng] = k;
            gtime[ng] = cyc;
            ng++;
         end
         step();
      end
      req_valid = 4'b0000;
      chk("rr_grant_count", 32'(ng), 32'd5);
      exp_order = '{0, 1, 2, 3, 0};
      for (int i = 0; i < 5; i++) begin
         if (i < ng) chk("rr_order", 32'(order[i]), 32'(exp_order[i]));
         if (i > 0 && i < ng) chk("rr_spacing", 32'(gtime[i] - gtime[i-1]), 32'd3);
      end
      repeat (4) step();

      // Backpressure: hold the response for 5 cycles while requester 3 waits.
      resp_ready = 1'b0;
      issue(1, 2'b10, 1'b0, 1'b1, g);
      req_valid[3] = 1'b1;
      req_op[7:6]  = 2'b01;
      req_a[3]     = 1'b1;
      req_b[3]     = 1'b1;
      wait_resp(r);
      for (int i = 0; i < 5; i++) begin
         chk("bp_resp_valid", 32'(resp_valid), 32'h1);
         chk("bp_resp_id", 32'(resp_id), 32'h1);
         chk("bp_resp_data", 32'(resp_data), 32'h1);
         chk("bp_req_ready", 32'(req_ready), 32'h0);
         @(negedge clk);
      end
      @(posedge clk);
      #1;
      resp_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("bp_idle_grant_req3", 32'(req_ready), 32'h8);
      step();
      req_valid[3] = 1'b0;
      repeat (4) step();

      // Reset during the EVAL cycle of req2 AND(1,1).
      issue(2, 2'b01, 1'b1, 1'b1, g);
      rst = 1'b1;
      step();
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("midrst_no_resp", 32'(resp_valid), 32'h0);
      end
      @(posedge clk);
      #1;
      req_valid = 4'b1111;
      @(negedge clk);
      chk("midrst_rr_ptr0", 32'(req_ready), 32'h1);
      step();
      req_valid = 4'b0000;
      repeat (4) step();

      // Fault: decoder forced to 4'b0011 during an OR(0,0).
      fault_on   = 1'b1;
      fault_data = 1'b1;
      force dut.dec_w = 4'b0011;
      issue(0, 2'b10, 1'b0, 1'b0, g);
      wait_resp(r);
      chk("fault_dec_err", 32'(dec_err), 32'h1);
      chk("fault_data", 32'(resp_data), 32'h1);
      step();
      release dut.dec_w;
      fault_on = 1'b0;
      issue(1, 2'b11, 1'b1, 1'b0, g);
      wait_resp(r);
      chk("post_fault_data", 32'(resp_data), 32'h1);
      chk("dec_err_sticky", 32'(dec_err), 32'h1);
      step();
      issue(2, 2'b01, 1'b0, 1'b1, g);
      wait_resp(r);
      chk("post_fault_data2", 32'(resp_data), 32'h0);
      chk("dec_err_sticky2", 32'(dec_err), 32'h1);
      step();
      do_reset(1);
      @(negedge clk);
      chk("dec_err_cleared", 32'(dec_err), 32'h0);
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Global bound so the run always ends.
   initial begin
      #200000;
      failures++;
      $display("FAIL watchdog: got no completion, required finish before 200000 time units");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
